core_mem_arbiter: RTL and testbench
===================================

CORE_MEM_ARBITER -- requirements
Module: core_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, request address width in bits.
REQ-002 Parameter DATA_W, default 32, data width in bits; write strobe width is DATA_W/8.
REQ-003 clk  input  1  core clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 i_req_valid / i_req_ready / i_req_addr  in / out / in  1 / 1 / ADDR_W  fetch read request.
REQ-006 i_rsp_valid / i_rsp_rdata  out / out  1 / DATA_W  fetch response.
REQ-007 d_req_valid / d_req_ready / d_req_addr / d_req_we / d_req_wstrb / d_req_wdata  in / out / in / in / in / in  1 / 1 / ADDR_W / 1 / DATA_W/8 / DATA_W  load/store request.
REQ-008 d_rsp_valid / d_rsp_rdata  out / out  1 / DATA_W  load/store response.
REQ-009 mem_req_valid / mem_req_ready / mem_req_addr / mem_req_we / mem_req_wstrb / mem_req_wdata  out / in / out / out / out / out  shared memory request port.
REQ-010 mem_rsp_valid / mem_rsp_rdata  in / in  1 / DATA_W  shared memory response; one per accepted request, reads and writes alike.
REQ-011 busy  output  1  high whenever FSM is not IDLE.

Function
REQ-012 FSM states IDLE, ISSUE, WAIT_RSP; at most one memory transaction outstanding.
REQ-013 IDLE: if any req_valid, latch winner's fields and owner into registers, go ISSUE next cycle; else stay.
REQ-014 Default priority: data beats fetch when both valid in the same cycle.
REQ-015 ISSUE: mem_req_valid=1 driven from latched registers; on mem_req_valid&&mem_req_ready pulse owner's req_ready for that cycle only, go WAIT_RSP; else hold all mem_req_* stable.
REQ-016 WAIT_RSP: on mem_rsp_valid assert owner's rsp_valid in the same cycle with rsp_rdata=mem_rsp_rdata (combinational), go IDLE; non-owner rsp_valid stays 0.
REQ-017 Minimum latency: req_valid seen in cycle N -> mem_req_valid in N+1 -> req_ready in N+1 if memory ready -> rsp_valid no earlier than N+2.
REQ-018 Fetch requests drive mem_req_we=0 and mem_req_wstrb=0.
REQ-019 Requester must hold req_valid and fields until req_ready; arbiter uses only fields latched in IDLE.
REQ-020 mem_rsp_valid in IDLE or ISSUE is ignored; no rsp_valid is generated.
REQ-021 New request is not sampled in the cycle WAIT_RSP completes; back-to-back transactions are spaced by at least one IDLE cycle.
REQ-022 rsp_rdata outputs are don't-care when the matching rsp_valid is 0; bench checks them only with valid.

Reset
REQ-023 rst_n low asynchronously forces IDLE, clears owner, round-robin pointer and latched fields to 0.
REQ-024 During and after reset all valid/ready outputs, busy and mem_req_* are 0.
REQ-025 Reset mid-transaction abandons it; a late mem_rsp_valid after release is ignored per REQ-020.

Configuration
REQ-026 With LETC_MEM_ARB_ROUND_ROBIN_EN defined, contention is resolved by a 1-bit pointer favouring the requester not granted last; pointer updates on every grant.
REQ-027 Without LETC_MEM_ARB_ROUND_ROBIN_EN, fixed priority per REQ-014 applies and no pointer flop exists.

Structure
REQ-028 mem_arb_state_e (IDLE, ISSUE, WAIT_RSP) and mem_arb_owner_e (OWNER_I, OWNER_D) belong in core_pkg.
REQ-029 Grant selection is a sub-module core_mem_arb_picker (two valids, pointer in, one-hot grant out); FSM and datapath stay in core_mem_arbiter.

Verification
REQ-030 Fetch only: i_req_addr=0x0000_1000, mem_req_ready=1, mem_rsp_valid two cycles later with rdata 0xDEADBEEF -> i_req_ready pulses once, i_rsp_rdata=0xDEADBEEF, d_rsp_valid never 1.
REQ-031 Both valid same cycle, fixed priority: d store addr 0x2000, wstrb 0xF, wdata 0x1234_5678 -> mem sees we=1 to 0x2000 first; fetch granted after d_rsp_valid.
REQ-032 LETC_MEM_ARB_ROUND_ROBIN_EN, both continuously valid for 4 transactions -> grant order D, I, D, I.
REQ-033 mem_req_ready low 3 cycles in ISSUE -> mem_req_addr/we/wdata stable, no req_ready until accept cycle.
REQ-034 rst_n asserted in WAIT_RSP, mem_rsp_valid pulsed 1 cycle after release -> no rsp_valid, busy=0, next request served normally.
REQ-035 Spurious mem_rsp_valid in IDLE -> no response outputs, state remains IDLE.

Source files
------------

// File: rtl/core_pkg.sv
// ---------------------------------------------------------------------------
// core_pkg
// Shared types for the core memory arbiter slice.
//   mem_arb_state_e : arbiter FSM states (IDLE, ISSUE, WAIT_RSP)
//   mem_arb_owner_e : which requester owns the outstanding transaction
//   grant_to_owner  : converts a one-hot {d, i} grant into an owner value
// Optional feature macro used by this slice: LETC_MEM_ARB_ROUND_ROBIN_EN
// ---------------------------------------------------------------------------
package core_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RSP = 2'd2
    } mem_arb_state_e;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } mem_arb_owner_e;

    // Bit positions inside the one-hot grant vector
    localparam int GRANT_I_BIT = 0;
    localparam int GRANT_D_BIT = 1;

    function automatic mem_arb_owner_e grant_to_owner(input logic [1:0] grant);
        return grant[GRANT_D_BIT] ? OWNER_D : OWNER_I;
    endfunction

endpackage

// File: rtl/core_mem_arb_picker.sv
// ---------------------------------------------------------------------------
// core_mem_arb_picker
// Purely combinational grant selection between the fetch and data requesters.
// Ports:
//   i_valid    in   fetch requester is asking
//   d_valid    in   data requester is asking
//   last_owner in   owner granted most recently (OWNER_I encoding = 0);
//                   on contention the other requester wins
//   grant      out  one-hot grant, bit GRANT_I_BIT = fetch, GRANT_D_BIT = data
// Fixed data-first priority falls out of tying last_owner to OWNER_I.
// ---------------------------------------------------------------------------
module core_mem_arb_picker
    import core_pkg::*;
(
    input  logic       i_valid,
    input  logic       d_valid,
    input  logic       last_owner,
    output logic [1:0] grant
);

    // Single requester wins outright; with both present the one not
    // granted last time is favoured.
    always_comb begin
        grant = 2'b00;
        if (i_valid && d_valid) begin
            if (last_owner == OWNER_I) begin
                grant[GRANT_D_BIT] = 1'b1;
            end else begin
                grant[GRANT_I_BIT] = 1'b1;
            end
        end else if (d_valid) begin
            grant[GRANT_D_BIT] = 1'b1;
        end else if (i_valid) begin
            grant[GRANT_I_BIT] = 1'b1;
        end
    end

endmodule

// File: rtl/core_mem_arbiter.sv
// ---------------------------------------------------------------------------
// core_mem_arbiter
// Shares one memory request/response port between the instruction fetch
// requester (i_*) and the load/store requester (d_*). One transaction is in
// flight at a time: IDLE picks and latches a winner, ISSUE presents it to
// memory until accepted, WAIT_RSP forwards the single response to the owner.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   i_req_* / i_rsp_*           fetch request (read only) and response
//   d_req_* / d_rsp_*           load/store request and response
//   mem_req_* / mem_rsp_*       shared memory port
//   busy                        high whenever the FSM is not IDLE
// Optional feature: define LETC_MEM_ARB_ROUND_ROBIN_EN to replace the fixed
// data-first priority with a 1-bit round-robin pointer.
// ---------------------------------------------------------------------------
module core_mem_arbiter
    import core_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  i_req_valid,
    output logic                  i_req_ready,
    input  logic [ADDR_W-1:0]     i_req_addr,
    output logic                  i_rsp_valid,
    output logic [DATA_W-1:0]     i_rsp_rdata,

    input  logic                  d_req_valid,
    output logic                  d_req_ready,
    input  logic [ADDR_W-1:0]     d_req_addr,
    input  logic                  d_req_we,
    input  logic [DATA_W/8-1:0]   d_req_wstrb,
    input  logic [DATA_W-1:0]     d_req_wdata,
    output logic                  d_rsp_valid,
    output logic [DATA_W-1:0]     d_rsp_rdata,

    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_W-1:0]     mem_req_addr,
    output logic                  mem_req_we,
    output logic [DATA_W/8-1:0]   mem_req_wstrb,
    output logic [DATA_W-1:0]     mem_req_wdata,
    input  logic                  mem_rsp_valid,
    input  logic [DATA_W-1:0]     mem_rsp_rdata,

    output logic                  busy
);

    mem_arb_state_e        state_q;
    mem_arb_state_e        state_d;
    mem_arb_owner_e        owner_q;
    logic [ADDR_W-1:0]     addr_q;
    logic                  we_q;
    logic [DATA_W/8-1:0]   wstrb_q;
    logic [DATA_W-1:0]     wdata_q;

    logic [1:0]            grant;
    logic                  last_owner;
    logic                  take_request;
    mem_arb_owner_e        winner;

    assign take_request = (state_q == IDLE) && (i_req_valid || d_req_valid);
    assign winner       = grant_to_owner(grant);

`ifdef LETC_MEM_ARB_ROUND_ROBIN_EN
    logic rr_last_q;

    // Remember who was granted last so contention alternates between
    // requesters; it moves on every grant, contended or not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last_q <= OWNER_I;
        end else if (take_request) begin
            rr_last_q <= winner;
        end
    end

    assign last_owner = rr_last_q;
`else
    // Pretending fetch was granted last makes data win every contention.
    assign last_owner = OWNER_I;
`endif

    core_mem_arb_picker u_picker (
        .i_valid    (i_req_valid),
        .d_valid    (d_req_valid),
        .last_owner (last_owner),
        .grant      (grant)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. WAIT_RSP always returns to IDLE, so a new request
    // is never sampled in the cycle a response completes.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (i_req_valid || d_req_valid) state_d = ISSUE;
            ISSUE:    if (mem_req_ready)              state_d = WAIT_RSP;
            WAIT_RSP: if (mem_rsp_valid)              state_d = IDLE;
            default:                                  state_d = IDLE;
        endcase
    end

    // Latch the winner's request only in IDLE; the memory port is driven
    // from these registers so it stays stable while memory stalls. Fetches
    // are always reads with no strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q <= OWNER_I;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wstrb_q <= '0;
            wdata_q <= '0;
        end else if (take_request) begin
            owner_q <= winner;
            if (winner == OWNER_D) begin
                addr_q  <= d_req_addr;
                we_q    <= d_req_we;
                wstrb_q <= d_req_wstrb;
                wdata_q <= d_req_wdata;
            end else begin
                addr_q  <= i_req_addr;
                we_q    <= 1'b0;
                wstrb_q <= '0;
                wdata_q <= '0;
            end
        end
    end

    assign mem_req_addr  = addr_q;
    assign mem_req_we    = we_q;
    assign mem_req_wstrb = wstrb_q;
    assign mem_req_wdata = wdata_q;
    assign i_rsp_rdata   = mem_rsp_rdata;
    assign d_rsp_rdata   = mem_rsp_rdata;

    // Output decode. Ready pulses only in the accept cycle; responses pass
    // straight through to the owner in WAIT_RSP and are dropped elsewhere.
    always_comb begin
        mem_req_valid = 1'b0;
        i_req_ready   = 1'b0;
        d_req_ready   = 1'b0;
        i_rsp_valid   = 1'b0;
        d_rsp_valid   = 1'b0;
        busy          = (state_q != IDLE);
        case (state_q)
            ISSUE: begin
                mem_req_valid = 1'b1;
                i_req_ready   = mem_req_ready && (owner_q == OWNER_I);
                d_req_ready   = mem_req_ready && (owner_q == OWNER_D);
            end
            WAIT_RSP: begin
                i_rsp_valid = mem_rsp_valid && (owner_q == OWNER_I);
                d_rsp_valid = mem_rsp_valid && (owner_q == OWNER_D);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_core_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_core_mem_arbiter
// Directed bench for core_mem_arbiter with hand-computed expectations.
// Honours LETC_MEM_ARB_ROUND_ROBIN_EN when choosing the contention order.
// ---------------------------------------------------------------------------
module tb_core_mem_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic                clk;
    logic                rst_n;
    logic                i_req_valid;
    logic                i_req_ready;
    logic [ADDR_W-1:0]   i_req_addr;
    logic                i_rsp_valid;
    logic [DATA_W-1:0]   i_rsp_rdata;
    logic                d_req_valid;
    logic                d_req_ready;
    logic [ADDR_W-1:0]   d_req_addr;
    logic                d_req_we;
    logic [DATA_W/8-1:0] d_req_wstrb;
    logic [DATA_W-1:0]   d_req_wdata;
    logic                d_rsp_valid;
    logic [DATA_W-1:0]   d_rsp_rdata;
    logic                mem_req_valid;
    logic                mem_req_ready;
    logic [ADDR_W-1:0]   mem_req_addr;
    logic                mem_req_we;
    logic [DATA_W/8-1:0] mem_req_wstrb;
    logic [DATA_W-1:0]   mem_req_wdata;
    logic                mem_rsp_valid;
    logic [DATA_W-1:0]   mem_rsp_rdata;
    logic                busy;

    int vectors    = 0;
    int miscompares = 0;

    core_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_req_valid   (i_req_valid),
        .i_req_ready   (i_req_ready),
        .i_req_addr    (i_req_addr),
        .i_rsp_valid   (i_rsp_valid),
        .i_rsp_rdata   (i_rsp_rdata),
        .d_req_valid   (d_req_valid),
        .d_req_ready   (d_req_ready),
        .d_req_addr    (d_req_addr),
        .d_req_we      (d_req_we),
        .d_req_wstrb   (d_req_wstrb),
        .d_req_wdata   (d_req_wdata),
        .d_rsp_valid   (d_rsp_valid),
        .d_rsp_rdata   (d_rsp_rdata),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_req_we    (mem_req_we),
        .mem_req_wstrb (mem_req_wstrb),
        .mem_req_wdata (mem_req_wdata),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_rdata (mem_rsp_rdata),
        .busy          (busy)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Move to 1 unit after the next rising edge; inputs change here.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    // One comparison: counts it, and on mismatch counts and reports it.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Hold reset for a few cycles then release it away from the clock edge.
    task automatic resetDut();
        rst_n = 1'b0;
        applyStimulus();
        applyStimulus();
        rst_n = 1'b1;
    endtask

    logic exp_d [4];

    // Directed sequence.
    initial begin
        rst_n = 1'b0;
        i_req_valid = 1'b0; i_req_addr = '0;
        d_req_valid = 1'b0; d_req_addr = '0; d_req_we = 1'b0;
        d_req_wstrb = '0; d_req_wdata = '0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = '0;

        // Reset state.
        applyStimulus();
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_mem_req_valid", mem_req_valid, 0);
        checkOutput("rst_mem_req_addr", mem_req_addr, 0);
        checkOutput("rst_i_req_ready", i_req_ready, 0);
        checkOutput("rst_d_req_ready", d_req_ready, 0);
        resetDut();

        // Fetch-only transaction.
        i_req_valid = 1'b1; i_req_addr = 32'h0000_1000; mem_req_ready = 1'b1;
        #1;
        checkOutput("f_idle_mem_valid", mem_req_valid, 0);
        checkOutput("f_idle_i_ready", i_req_ready, 0);
        applyStimulus();
        checkOutput("f_issue_mem_valid", mem_req_valid, 1);
        checkOutput("f_issue_addr", mem_req_addr, 32'h0000_1000);
        checkOutput("f_issue_we", mem_req_we, 0);
        checkOutput("f_issue_wstrb", mem_req_wstrb, 0);
        checkOutput("f_issue_i_ready", i_req_ready, 1);
        checkOutput("f_issue_busy", busy, 1);
        applyStimulus();
        i_req_valid = 1'b0;
        #1;
        checkOutput("f_wait_i_ready", i_req_ready, 0);
        checkOutput("f_wait_mem_valid", mem_req_valid, 0);
        checkOutput("f_wait_i_rsp", i_rsp_valid, 0);
        checkOutput("f_wait_busy", busy, 1);
        applyStimulus();
        mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'hDEAD_BEEF;
        #1;
        checkOutput("f_rsp_valid", i_rsp_valid, 1);
        checkOutput("f_rsp_rdata", i_rsp_rdata, 32'hDEAD_BEEF);
        checkOutput("f_rsp_d_valid", d_rsp_valid, 0);
        applyStimulus();
        mem_rsp_valid = 1'b0;
        #1;
        checkOutput("f_done_busy", busy, 0);
        checkOutput("f_done_i_rsp", i_rsp_valid, 0);

        // Contention: data store wins, fetch follows after the response.
        d_req_valid = 1'b1; d_req_addr = 32'h0000_2000; d_req_we = 1'b1;
        d_req_wstrb = 4'hF; d_req_wdata = 32'h1234_5678;
        i_req_valid = 1'b1; i_req_addr = 32'h0000_1004;
        applyStimulus();
        checkOutput("c_issue_addr", mem_req_addr, 32'h0000_2000);
        checkOutput("c_issue_we", mem_req_we, 1);
        checkOutput("c_issue_wstrb", mem_req_wstrb, 4'hF);
        checkOutput("c_issue_wdata", mem_req_wdata, 32'h1234_5678);
        checkOutput("c_issue_d_ready", d_req_ready, 1);
        checkOutput("c_issue_i_ready", i_req_ready, 0);
        applyStimulus();
        d_req_valid = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h0;
        #1;
        checkOutput("c_d_rsp", d_rsp_valid, 1);
        checkOutput("c_i_rsp_during_d", i_rsp_valid, 0);
        checkOutput("c_wait_i_ready", i_req_ready, 0);
        applyStimulus();
        mem_rsp_valid = 1'b0;
        #1;
        checkOutput("c_gap_busy", busy, 0);
        checkOutput("c_gap_mem_valid", mem_req_valid, 0);
        applyStimulus();
        checkOutput("c_f_addr", mem_req_addr, 32'h0000_1004);
        checkOutput("c_f_we", mem_req_we, 0);
        checkOutput("c_f_i_ready", i_req_ready, 1);
        applyStimulus();
        i_req_valid = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'hCAFE_F00D;
        #1;
        checkOutput("c_f_rsp", i_rsp_valid, 1);
        checkOutput("c_f_rdata", i_rsp_rdata, 32'hCAFE_F00D);
        checkOutput("c_f_d_rsp", d_rsp_valid, 0);
        applyStimulus();
        mem_rsp_valid = 1'b0;

        // Memory stalls three cycles in ISSUE.
        d_req_valid = 1'b1; d_req_addr = 32'h0000_3000; d_req_we = 1'b1;
        d_req_wstrb = 4'h3; d_req_wdata = 32'hA5A5_A5A5; mem_req_ready = 1'b0;
        applyStimulus();
        for (int k = 0; k < 3; k++) begin
            checkOutput("s_mem_valid", mem_req_valid, 1);
            checkOutput("s_addr", mem_req_addr, 32'h0000_3000);
            checkOutput("s_we", mem_req_we, 1);
            checkOutput("s_wdata", mem_req_wdata, 32'hA5A5_A5A5);
            checkOutput("s_d_ready", d_req_ready, 0);
            applyStimulus();
        end
        mem_req_ready = 1'b1;
        #1;
        checkOutput("s_accept_d_ready", d_req_ready, 1);
        checkOutput("s_accept_wstrb", mem_req_wstrb, 4'h3);
        applyStimulus();
        d_req_valid = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h0BAD_F00D;
        #1;
        checkOutput("s_d_rsp", d_rsp_valid, 1);
        checkOutput("s_d_rdata", d_rsp_rdata, 32'h0BAD_F00D);
        applyStimulus();
        mem_rsp_valid = 1'b0;

        // Spurious response while idle.
        mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h1111_2222;
        #1;
        checkOutput("sp_i_rsp", i_rsp_valid, 0);
        checkOutput("sp_d_rsp", d_rsp_valid, 0);
        applyStimulus();
        mem_rsp_valid = 1'b0;
        #1;
        checkOutput("sp_busy", busy, 0);
        checkOutput("sp_mem_valid", mem_req_valid, 0);

        // Reset while waiting for a response; late response is ignored.
        i_req_valid = 1'b1; i_req_addr = 32'h0000_4000;
        applyStimulus();
        checkOutput("r_issue_i_ready", i_req_ready, 1);
        applyStimulus();
        i_req_valid = 1'b0;
        checkOutput("r_wait_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("r_in_rst_busy", busy, 0);
        checkOutput("r_in_rst_mem_valid", mem_req_valid, 0);
        checkOutput("r_in_rst_addr", mem_req_addr, 0);
        applyStimulus();
        rst_n = 1'b1;
        applyStimulus();
        mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h0000_0BAD;
        #1;
        checkOutput("r_late_i_rsp", i_rsp_valid, 0);
        checkOutput("r_late_d_rsp", d_rsp_valid, 0);
        checkOutput("r_late_busy", busy, 0);
        applyStimulus();
        mem_rsp_valid = 1'b0;
        d_req_valid = 1'b1; d_req_addr = 32'h0000_5000; d_req_we = 1'b0;
        d_req_wstrb = 4'h0; d_req_wdata = 32'h0;
        applyStimulus();
        checkOutput("r_next_addr", mem_req_addr, 32'h0000_5000);
        checkOutput("r_next_we", mem_req_we, 0);
        checkOutput("r_next_d_ready", d_req_ready, 1);
        applyStimulus();
        d_req_valid = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h0000_55AA;
        #1;
        checkOutput("r_next_d_rsp", d_rsp_valid, 1);
        checkOutput("r_next_rdata", d_rsp_rdata, 32'h0000_55AA);
        applyStimulus();
        mem_rsp_valid = 1'b0;

        // Both requesters continuously valid for four transactions.
`ifdef LETC_MEM_ARB_ROUND_ROBIN_EN
        exp_d[0] = 1'b1; exp_d[1] = 1'b0; exp_d[2] = 1'b1; exp_d[3] = 1'b0;
`else
        exp_d[0] = 1'b1; exp_d[1] = 1'b1; exp_d[2] = 1'b1; exp_d[3] = 1'b1;
`endif
        resetDut();
        i_req_valid = 1'b1; i_req_addr = 32'h0000_6000;
        d_req_valid = 1'b1; d_req_addr = 32'h0000_7000; d_req_we = 1'b0;
        for (int t = 0; t < 4; t++) begin
            applyStimulus();
            checkOutput("rr_mem_valid", mem_req_valid, 1);
            checkOutput("rr_addr", mem_req_addr, exp_d[t] ? 32'h0000_7000 : 32'h0000_6000);
            checkOutput("rr_d_ready", d_req_ready, exp_d[t]);
            checkOutput("rr_i_ready", i_req_ready, !exp_d[t]);
            applyStimulus();
            mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h100 + t;
            #1;
            checkOutput("rr_d_rsp", d_rsp_valid, exp_d[t]);
            checkOutput("rr_i_rsp", i_rsp_valid, !exp_d[t]);
            checkOutput("rr_rdata", exp_d[t] ? d_rsp_rdata : i_rsp_rdata, 32'h100 + t);
            applyStimulus();
            mem_rsp_valid = 1'b0;
            #1;
            checkOutput("rr_gap_busy", busy, 0);
        end
        i_req_valid = 1'b0; d_req_valid = 1'b0;
        applyStimulus();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
